// File: rtl/uart_rx_frame_chk_if.sv
// uart_rx_frame_chk_if: serial line, frame config and status bundle for the UART receive frame checker
interface uart_rx_frame_chk_if #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
);
  logic               rx_in;
  logic [PRESC_W-1:0] prescale;
  logic               par_en;
  logic               par_typ;
  logic               stop2;
  logic               err_clr;
  logic [DATA_W-1:0]  data_out;
  logic               data_valid;
  logic               strt_glitch;
  logic               par_err;
  logic               stop_err;
  logic [2:0]         err_sticky;
  logic               busy;
  modport master (
    output rx_in, prescale, par_en, par_typ, stop2, err_clr,
    input  data_out, data_valid, strt_glitch, par_err, stop_err, err_sticky, busy
  );
  modport slave (
    input  rx_in, prescale, par_en, par_typ, stop2, err_clr,
    output data_out, data_valid, strt_glitch, par_err, stop_err, err_sticky, busy
  );
endinterface

// File: rtl/uart_rx_frame_chk.sv
// uart_rx_frame_chk: oversampling UART receiver with 3-point majority vote and start/parity/stop checks
module uart_rx_frame_chk #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input logic                clk,
  input logic                rst,
  uart_rx_frame_chk_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t             state_q;
  logic               rx_s1_q, rx_s_q;
  logic [PRESC_W-1:0] p_q, edge_q;
  logic [3:0]         bit_q;
  logic [2:0]         smp_q;
  logic [DATA_W-1:0]  sh_q, data_q;
  logic               pe_q, pt_q, s2_q, perr_f_q, serr_f_q;
  logic               dv_q, gl_q, pp_q, sp_q;
  logic [2:0]         sticky_q;
  logic [PRESC_W-1:0] mid, presc_c;
  logic               vote, last;
  // bit timing helpers: clamped prescale, bit centre, majority vote and decision strobe
  always_comb begin
    presc_c = (bus.prescale < PRESC_W'(8)) ? PRESC_W'(8) : bus.prescale;
    mid     = p_q >> 1;
    vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    last    = edge_q == p_q - 1'b1;
  end
  // synchroniser, oversampling, frame FSM and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rx_s1_q  <= 1'b1;
      rx_s_q   <= 1'b1;
      p_q      <= PRESC_W'(8);
      edge_q   <= '0;
      bit_q    <= '0;
      smp_q    <= '0;
      sh_q     <= '0;
      data_q   <= '0;
      pe_q     <= 1'b0;
      pt_q     <= 1'b0;
      s2_q     <= 1'b0;
      perr_f_q <= 1'b0;
      serr_f_q <= 1'b0;
      dv_q     <= 1'b0;
      gl_q     <= 1'b0;
      pp_q     <= 1'b0;
      sp_q     <= 1'b0;
      sticky_q <= '0;
    end else begin
      rx_s1_q  <= bus.rx_in;
      rx_s_q   <= rx_s1_q;
      dv_q     <= 1'b0;
      gl_q     <= 1'b0;
      pp_q     <= 1'b0;
      sp_q     <= 1'b0;
      sticky_q <= (sticky_q & ~{3{bus.err_clr}}) | {sp_q, pp_q, gl_q};
      if (state_q != IDLE) begin
        edge_q <= last ? '0 : edge_q + 1'b1;
        if (edge_q == mid - 1'b1) smp_q[0] <= rx_s_q;
        if (edge_q == mid)        smp_q[1] <= rx_s_q;
        if (edge_q == mid + 1'b1) smp_q[2] <= rx_s_q;
      end
      case (state_q)
        IDLE: if (!rx_s_q) begin
          p_q     <= presc_c;
          pe_q    <= bus.par_en;
          pt_q    <= bus.par_typ;
          s2_q    <= bus.stop2;
          edge_q  <= '0;
          state_q <= START;
        end
        START: if (last) begin
          if (vote) begin
            gl_q    <= 1'b1;
            state_q <= IDLE;
          end else begin
            bit_q    <= '0;
            perr_f_q <= 1'b0;
            serr_f_q <= 1'b0;
            state_q  <= DATA;
          end
        end
        DATA: if (last) begin
          sh_q  <= {vote, sh_q[DATA_W-1:1]};
          bit_q <= bit_q + 1'b1;
          if (bit_q == 4'(DATA_W - 1)) begin
            bit_q   <= '0;
            state_q <= pe_q ? PARITY : STOP;
          end
        end
        PARITY: if (last) begin
          if (vote != (^sh_q ^ pt_q)) begin
            pp_q     <= 1'b1;
            perr_f_q <= 1'b1;
          end
          state_q <= STOP;
        end
        STOP: if (last) begin
          if (!vote && !serr_f_q) begin
            sp_q     <= 1'b1;
            serr_f_q <= 1'b1;
          end
          bit_q <= bit_q + 1'b1;
          if (bit_q == 4'(s2_q)) begin
            state_q <= IDLE;
            if (vote && !perr_f_q && !serr_f_q) begin
              data_q <= sh_q;
              dv_q   <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.data_out    = data_q;
  assign bus.data_valid  = dv_q;
  assign bus.strt_glitch = gl_q;
  assign bus.par_err     = pp_q;
  assign bus.stop_err    = sp_q;
  assign bus.err_sticky  = sticky_q;
  assign bus.busy        = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// tb_uart_rx_frame_chk: table-driven frames with a pulse scoreboard plus glitch, clear-vs-set and reset corner cases
module tb_uart_rx_frame_chk;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_rx_frame_chk_if bus ();
  uart_rx_frame_chk dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [7:0] data;
    logic [5:0] presc;
    logic       pe, pt, s2, pflip;
    logic [1:0] slow;
    int         inv_bit, inv_off;
    logic       ok;
    logic [2:0] sticky;
  } vec_t;
  typedef struct {
    logic [3:0] ev;
    logic [7:0] data;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [7:0] last_good = 8'h00;
  vec_t tbl[10];
  vec_t v;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask
  // pulse scoreboard: every pulse cycle pops one expectation {dv, glitch, par, stop}
  always @(negedge clk) begin
    logic [3:0] ev;
    exp_t e;
    ev = {bus.data_valid, bus.strt_glitch, bus.par_err, bus.stop_err};
    if (!rst && ev != 4'b0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse got %b want none", ev);
      end else begin
        e = q.pop_front();
        if (ev !== e.ev || (e.ev[3] && bus.data_out !== e.data)) begin
          errors++;
          $display("FAIL pulse got %b data %0h want %b data %0h", ev, bus.data_out, e.ev, e.data);
        end
      end
    end
  end
  task automatic send(input vec_t f, input int maxcyc);
    int p, nb, n;
    logic [12:0] bits;
    p = (f.presc < 6'd8) ? 8 : int'(f.presc);
    n = 0;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = f.data[i];
    nb = 9;
    if (f.pe) begin
      bits[nb] = ^f.data ^ f.pt ^ f.pflip;
      nb++;
    end
    bits[nb] = ~f.slow[0];
    nb++;
    if (f.s2) begin
      bits[nb] = ~f.slow[1];
      nb++;
    end
    bus.prescale = f.presc;
    bus.par_en   = f.pe;
    bus.par_typ  = f.pt;
    bus.stop2    = f.s2;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < p; c++)
        if (n < maxcyc) begin
          bus.rx_in = bits[b] ^ (b == f.inv_bit && c == f.inv_off);
          @(posedge clk);
          #1;
          n++;
        end
    bus.rx_in = 1'b1;
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    repeat (3) @(posedge clk);
    while ((bus.busy || q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL idle_timeout got busy=%b pending=%0d want idle", bus.busy, q.size());
      q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic clear_sticky();
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
  endtask
  task automatic push_exp(input vec_t f);
    if (f.sticky[1]) q.push_back('{4'b0010, 8'h00});
    if (f.sticky[2]) q.push_back('{4'b0001, 8'h00});
    if (f.ok) q.push_back('{4'b1000, f.data});
  endtask
  initial begin
    tbl[0] = '{8'hA5, 6'd8,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, -1,  0, 1'b1, 3'b000};
    tbl[1] = '{8'hA5, 6'd8,  1'b1, 1'b0, 1'b0, 1'b1, 2'b00, -1,  0, 1'b0, 3'b010};
    tbl[2] = '{8'h5A, 6'd16, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, -1,  0, 1'b0, 3'b100};
    tbl[3] = '{8'h3C, 6'd16, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,  3, 10, 1'b1, 3'b000};
    tbl[4] = '{8'hFF, 6'd8,  1'b1, 1'b1, 1'b1, 1'b0, 2'b00, -1,  0, 1'b1, 3'b000};
    tbl[5] = '{8'h00, 6'd3,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1,  0, 1'b1, 3'b000};
    tbl[6] = '{8'h81, 6'd8,  1'b0, 1'b0, 1'b1, 1'b0, 2'b11, -1,  0, 1'b0, 3'b100};
    tbl[7] = '{8'h6E, 6'd12, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, -1,  0, 1'b0, 3'b110};
    tbl[8] = '{8'h93, 6'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, -1,  0, 1'b1, 3'b000};
    tbl[9] = '{8'hC3, 6'd8,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, -1,  0, 1'b0, 3'b100};
    bus.rx_in    = 1'b1;
    bus.prescale = 6'd8;
    bus.par_en   = 1'b0;
    bus.par_typ  = 1'b0;
    bus.stop2    = 1'b0;
    bus.err_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", 32'(bus.data_out), 32'h0);
    chk("rst_pulses", 32'({bus.data_valid, bus.strt_glitch, bus.par_err, bus.stop_err}), 32'h0);
    chk("rst_sticky", 32'(bus.err_sticky), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      clear_sticky();
      push_exp(tbl[i]);
      send(tbl[i], 1000);
      wait_idle();
      if (tbl[i].ok) last_good = tbl[i].data;
      chk($sformatf("vec%0d_data_out", i), 32'(bus.data_out), 32'(last_good));
      chk($sformatf("vec%0d_sticky", i), 32'(bus.err_sticky), 32'(tbl[i].sticky));
    end
    clear_sticky();
    bus.prescale = 6'd8;
    q.push_back('{4'b0100, 8'h00});
    bus.rx_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.rx_in = 1'b1;
    wait_idle();
    chk("glitch_sticky", 32'(bus.err_sticky), 32'h1);
    chk("glitch_data_out", 32'(bus.data_out), 32'(last_good));
    clear_sticky();
    v = '{8'h5C, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, -1, 0, 1'b0, 3'b010};
    push_exp(v);
    fork
      send(v, 1000);
      begin
        int n;
        n = 0;
        while (!bus.par_err && n < 300) begin
          @(negedge clk);
          n++;
        end
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
      end
    join
    wait_idle();
    chk("clr_vs_set_sticky1", 32'(bus.err_sticky[1]), 32'h1);
    clear_sticky();
    chk("clr_sticky", 32'(bus.err_sticky), 32'h0);
    v = '{8'h4B, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1, 0, 1'b1, 3'b000};
    send(v, 32);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_data_out", 32'(bus.data_out), 32'h0);
    chk("midrst_pulses", 32'({bus.data_valid, bus.strt_glitch, bus.par_err, bus.stop_err}), 32'h0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    push_exp(v);
    send(v, 1000);
    wait_idle();
    chk("after_rst_data_out", 32'(bus.data_out), 32'h4B);
    chk("after_rst_sticky", 32'(bus.err_sticky), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
